// File: rtl/sfr_bit_ctrl_pkg.sv
// sfr_bit_ctrl_pkg: command codes, FSM states and bit-write helpers; SFR_BIT_CTRL_JBC_EN enables cmd 101 (JBC)
package sfr_bit_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_READ = 3'b000,
        CMD_SET  = 3'b001,
        CMD_CLR  = 3'b010,
        CMD_CPL  = 3'b011,
        CMD_MOVC = 3'b100,
        CMD_JBC  = 3'b101
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [7:0] bit_pack(input logic [2:0] idx, input logic val);
        return {4'b0, idx, val};
    endfunction

    function automatic logic is_legal(input logic [2:0] cmd);
`ifdef SFR_BIT_CTRL_JBC_EN
        return cmd <= 3'b101;
`else
        return cmd <= 3'b100;
`endif
    endfunction

    function automatic logic direct_wr(input logic [2:0] cmd);
        return cmd == CMD_SET || cmd == CMD_CLR || cmd == CMD_MOVC;
    endfunction

    // new bit value; bitv is the bit read back (only CPL depends on it, JBC always clears)
    function automatic logic wr_val(input logic [2:0] cmd, input logic c, input logic bitv);
        return (cmd == CMD_SET) | ((cmd == CMD_MOVC) & c) | ((cmd == CMD_CPL) & ~bitv);
    endfunction

endpackage

// File: rtl/sfr_bit_ctrl_map.sv
// bit_addr_map: 8051 bit address to byte address, bit index and SFR-region flag
module bit_addr_map (
    input  logic [7:0] bit_addr,
    output logic [7:0] byte_addr,
    output logic [2:0] idx,
    output logic       sfr
);
    assign sfr       = bit_addr[7];
    assign idx       = bit_addr[2:0];
    assign byte_addr = sfr ? {bit_addr[7:3], 3'b000} : 8'h20 + {4'b0, bit_addr[6:3]};
endmodule

// File: rtl/sfr_bit_ctrl.sv
// sfr_bit_ctrl: bit-addressable access engine issuing byte reads and bit/byte write strobes; SFR_BIT_CTRL_JBC_EN enables JBC
module sfr_bit_ctrl
    import sfr_bit_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic [2:0] i_cmd,
    input  logic [7:0] i_bit_addr,
    input  logic       i_c,
    input  logic [7:0] i_rd_data,
    output logic [7:0] o_addr,
    output logic       o_rd_en,
    output logic       o_wr_byte,
    output logic       o_wr_bit,
    output logic [7:0] o_byte,
    output logic       o_bit,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);
    logic [7:0] map_addr;
    logic [2:0] map_idx;
    logic       map_sfr;
    state_t     state;
    cmd_t       cmd;
    logic [2:0] idx;
    logic       sfr;
    logic       c;
    logic       cap_bit;
    logic       new_val;
    logic [7:0] rmw_byte;

    bit_addr_map u_map (
        .bit_addr (i_bit_addr),
        .byte_addr(map_addr),
        .idx      (map_idx),
        .sfr      (map_sfr)
    );

    assign o_busy   = state != ST_IDLE;
    assign cap_bit  = i_rd_data[idx];
    assign new_val  = wr_val(cmd, c, cap_bit);
    assign rmw_byte = (i_rd_data & ~(8'd1 << idx)) | ({7'd0, new_val} << idx);

    // FSM with registered outputs that reflect the state being entered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cmd       <= CMD_READ;
            idx       <= '0;
            sfr       <= 1'b0;
            c         <= 1'b0;
            o_addr    <= '0;
            o_rd_en   <= 1'b0;
            o_wr_byte <= 1'b0;
            o_wr_bit  <= 1'b0;
            o_byte    <= '0;
            o_bit     <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_rd_en   <= 1'b0;
            o_wr_byte <= 1'b0;
            o_wr_bit  <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            case (state)
                ST_IDLE: if (i_req) begin
                    cmd    <= cmd_t'(i_cmd);
                    idx    <= map_idx;
                    sfr    <= map_sfr;
                    c      <= i_c;
                    o_addr <= map_addr;
                    if (!is_legal(i_cmd)) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                        o_err  <= 1'b1;
                    end else if (map_sfr && direct_wr(i_cmd)) begin
                        state    <= ST_WR;
                        o_wr_bit <= 1'b1;
                        o_byte   <= bit_pack(map_idx, wr_val(i_cmd, i_c, 1'b0));
                    end else begin
                        state   <= ST_RD;
                        o_rd_en <= 1'b1;
                    end
                end
                ST_RD: state <= ST_CAP;
                ST_CAP: begin
                    o_bit <= cap_bit;
                    if (cmd == CMD_READ || (cmd == CMD_JBC && !cap_bit)) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                    end else begin
                        state     <= ST_WR;
                        o_wr_bit  <= sfr;
                        o_wr_byte <= !sfr;
                        o_byte    <= sfr ? bit_pack(idx, new_val) : rmw_byte;
                    end
                end
                ST_WR: begin
                    state  <= ST_DONE;
                    o_done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sfr_bit_ctrl.sv
// tb_sfr_bit_ctrl: directed self-checking bench for sfr_bit_ctrl
module tb_sfr_bit_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [2:0] cmd = '0;
    logic [7:0] bit_addr = '0;
    logic       c = 1'b0;
    logic [7:0] rd_data = '0;
    logic [7:0] addr;
    logic       rd_en;
    logic       wr_byte;
    logic       wr_bit;
    logic [7:0] obyte;
    logic       obit;
    logic       busy;
    logic       done;
    logic       err;
    int         total = 0;
    int         passed = 0;
    int         n_rd = 0;
    int         n_wbyte = 0;
    int         n_wbit = 0;
    int         n_done = 0;
    int         n_err = 0;

    sfr_bit_ctrl dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_cmd     (cmd),
        .i_bit_addr(bit_addr),
        .i_c       (c),
        .i_rd_data (rd_data),
        .o_addr    (addr),
        .o_rd_en   (rd_en),
        .o_wr_byte (wr_byte),
        .o_wr_bit  (wr_bit),
        .o_byte    (obyte),
        .o_bit     (obit),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_rd    += int'(rd_en);
        n_wbyte += int'(wr_byte);
        n_wbit  += int'(wr_bit);
        n_done  += int'(done);
        n_err   += int'(err);
    endtask

    // drive one request through the accept edge; returns in cycle T0+1
    task automatic start(input logic [2:0] k, input logic [7:0] b, input logic cv, input logic [7:0] rd, input logic hold);
        n_rd = 0; n_wbyte = 0; n_wbit = 0; n_done = 0; n_err = 0;
        cmd = k; bit_addr = b; c = cv; rd_data = rd; req = 1'b1;
        tick();
        req = hold;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_addr", addr, 8'h00);
        chk("rst_strobes", {rd_en, wr_byte, wr_bit, done, err, busy, obit}, 7'd0);
        chk("rst_byte", obyte, 8'h00);

        // SET ACC.3
        start(3'b001, 8'hE3, 1'b0, 8'h00, 1'b0);
        chk("set_wr_bit", wr_bit, 1'b1);
        chk("set_addr", addr, 8'hE0);
        chk("set_byte", obyte, 8'h07);
        chk("set_busy", busy, 1'b1);
        tick();
        chk("set_done", done, 1'b1);
        tick();
        chk("set_idle", busy, 1'b0);
        chk("set_no_rd", n_rd, 0);
        chk("set_one_wr", n_wbit, 1);

        // CPL RAM bit 0x05 (byte 0x20 bit 5) with data A0
        start(3'b011, 8'h05, 1'b0, 8'hA0, 1'b0);
        chk("cpl_rd_en", rd_en, 1'b1);
        chk("cpl_rd_addr", addr, 8'h20);
        tick();
        tick();
        chk("cpl_wr_byte", wr_byte, 1'b1);
        chk("cpl_byte", obyte, 8'h80);
        chk("cpl_wr_addr", addr, 8'h20);
        tick();
        chk("cpl_done", done, 1'b1);
        chk("cpl_bit", obit, 1'b1);
        tick();
        chk("cpl_counts", {n_rd[3:0], n_wbyte[3:0], n_wbit[3:0]}, 12'h110);

        // READ 0xD7 (PSW.7) with data 80
        start(3'b000, 8'hD7, 1'b0, 8'h80, 1'b0);
        chk("rd_addr", addr, 8'hD0);
        chk("rd_rd_en", rd_en, 1'b1);
        tick();
        tick();
        chk("rd_done", done, 1'b1);
        chk("rd_bit", obit, 1'b1);
        tick();
        chk("rd_no_wr", n_wbit + n_wbyte, 0);

        // MOVC c=1 into RAM bit 0x7F (byte 0x2F bit 7), data 01
        start(3'b100, 8'h7F, 1'b1, 8'h01, 1'b0);
        chk("movc_addr", addr, 8'h2F);
        tick();
        tick();
        chk("movc_wr_byte", wr_byte, 1'b1);
        chk("movc_byte", obyte, 8'h81);
        tick();
        chk("movc_done", done, 1'b1);
        tick();

        // CLR SFR bit 0x8A: bit-write with val 0
        start(3'b010, 8'h8A, 1'b1, 8'hFF, 1'b0);
        chk("clr_sfr_addr", addr, 8'h88);
        chk("clr_sfr_byte", obyte, 8'h04);
        chk("clr_sfr_wr", wr_bit, 1'b1);
        tick();
        tick();

        // illegal cmd 110 with request held while busy
        start(3'b110, 8'h20, 1'b0, 8'h00, 1'b1);
        chk("ill_done", done, 1'b1);
        chk("ill_err", err, 1'b1);
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("ill_one_accept", n_done, 1);
        chk("ill_no_strobes", n_rd + n_wbit + n_wbyte, 0);

        // READ held request: exactly one accept across RD/CAP/DONE
        start(3'b000, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("hold_one_rd", n_rd, 1);
        chk("hold_one_done", n_done, 1);

        // reset during CAP of CLR RAM bit 0x10
        start(3'b010, 8'h10, 1'b0, 8'hFF, 1'b0);
        chk("rstmid_addr", addr, 8'h22);
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_outs", {rd_en, wr_byte, wr_bit, done, err, busy, obit}, 7'd0);
        chk("rstmid_addr0", addr, 8'h00);
        chk("rstmid_byte0", obyte, 8'h00);
        rst = 1'b0;
        tick();
        tick();
        chk("rstmid_no_wr", n_wbyte, 0);
        chk("rstmid_no_done", n_done, 0);

`ifdef SFR_BIT_CTRL_JBC_EN
        start(3'b101, 8'hE0, 1'b0, 8'h01, 1'b0);
        chk("jbc1_rd", rd_en, 1'b1);
        tick();
        tick();
        chk("jbc1_wr_bit", wr_bit, 1'b1);
        chk("jbc1_byte", obyte, 8'h00);
        chk("jbc1_bit", obit, 1'b1);
        tick();
        chk("jbc1_done", done, 1'b1);
        tick();
        start(3'b101, 8'hE0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        chk("jbc0_done", done, 1'b1);
        chk("jbc0_bit", obit, 1'b0);
        tick();
        chk("jbc0_no_wr", n_wbit + n_wbyte, 0);
`else
        start(3'b101, 8'hE0, 1'b0, 8'h01, 1'b0);
        chk("jbc_ill_done", done, 1'b1);
        chk("jbc_ill_err", err, 1'b1);
        tick();
        tick();
        chk("jbc_ill_no_access", n_rd + n_wbit + n_wbyte, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
